// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter: round-robin arbiter feeding one character at a time     |
// | to a shared UART transmitter. Optional watchdog: UART_TX_ARB_WATCHDOG_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          parity_enable_cfg,
  input  logic                          parity_type_cfg,
  output logic                          tx_data_valid,
  output logic [DATA_WIDTH-1:0]         tx_parallel_data,
  output logic                          tx_parity_enable,
  output logic                          tx_parity_type,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          arb_busy,
  output logic                          timeout_err
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic [GW-1:0]         win;
  logic                  accept;
  logic                  wd_expire;

  // First valid requester after 'last', wrapping, ending at 'last' itself.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0] last);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && v[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
    return pick;
  endfunction

  assign win    = rr_pick(req_valid, last_grant_q);
  assign accept = !reset && (state_q == ST_IDLE) && !tx_busy && (|req_valid);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    data_d       = data_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_LAUNCH;
          last_grant_d = win;
          grant_id_d   = win;
          data_d       = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          par_en_d     = parity_enable_cfg;
          par_type_d   = parity_type_cfg;
        end
      end
      ST_LAUNCH:    state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy)        state_d = ST_WAIT_DONE;
        else if (wd_expire) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      data_q       <= '0;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      data_q       <= data_d;
      par_en_q     <= par_en_d;
      par_type_q   <= par_type_d;
    end
  end

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q;

  // Counts consecutive idle-transmitter cycles spent waiting for tx_busy.
  always_comb begin
    wd_cnt_d  = '0;
    wd_expire = 1'b0;
    if ((state_q == ST_WAIT_BUSY) && !tx_busy) begin
      if (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1)) wd_expire = 1'b1;
      else                                      wd_cnt_d  = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= wd_expire;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign tx_data_valid    = (state_q == ST_LAUNCH);
  assign arb_busy         = (state_q != ST_IDLE);
  assign tx_parallel_data = data_q;
  assign tx_parity_enable = par_en_q;
  assign tx_parity_type   = par_type_q;
  assign grant_id         = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Directed testbench for uart_tx_arbiter (default parameters).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        parity_enable_cfg;
  logic        parity_type_cfg;
  logic        tx_data_valid;
  logic [7:0]  tx_parallel_data;
  logic        tx_parity_enable;
  logic        tx_parity_type;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .parity_enable_cfg(parity_enable_cfg),
    .parity_type_cfg(parity_type_cfg), .tx_data_valid(tx_data_valid),
    .tx_parallel_data(tx_parallel_data), .tx_parity_enable(tx_parity_enable),
    .tx_parity_type(tx_parity_type), .tx_busy(tx_busy), .grant_id(grant_id),
    .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_data;
    reset = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    parity_enable_cfg = 1'b0; parity_type_cfg = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_txv", 32'(tx_data_valid), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_busy", 32'(arb_busy), 0);
    check("rst_data", 32'(tx_parallel_data), 0);
    check("rst_tmo", 32'(timeout_err), 0);

    // Single request from requester 1
    req_valid = 4'b0010; req_data[8 +: 8] = 8'hE6;
    parity_enable_cfg = 1'b1; parity_type_cfg = 1'b0;
    #1;
    check("single_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("single_txv", 32'(tx_data_valid), 1);
    check("single_data", 32'(tx_parallel_data), 32'hE6);
    check("single_grant", 32'(grant_id), 1);
    check("single_pen", 32'(tx_parity_enable), 1);
    check("single_ptype", 32'(tx_parity_type), 0);
    check("single_abusy", 32'(arb_busy), 1);
    tick();
    check("single_txv_1cyc", 32'(tx_data_valid), 0);
    tx_busy = 1'b1;
    tick(); tick(); tick();
    check("single_abusy_done", 32'(arb_busy), 1);
    tx_busy = 1'b0;
    tick();
    check("single_idle", 32'(arb_busy), 0);
    check("single_hold_grant", 32'(grant_id), 1);
    check("single_hold_data", 32'(tx_parallel_data), 32'hE6);

    // Round-robin order from reset: 0,1,2,3,0
    reset = 1'b1; tick(); reset = 1'b0;
    req_valid = 4'b1111; req_data = 32'hD4C3B2A1;
    parity_enable_cfg = 1'b0; parity_type_cfg = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_data = 8'hA1 + 8'(i % 4) * 8'h11;
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << (i % 4)));
      tick();
      check("rr_grant", 32'(grant_id), 32'(i % 4));
      check("rr_txv", 32'(tx_data_valid), 1);
      check("rr_data", 32'(tx_parallel_data), 32'(exp_data));
      check("rr_ptype", 32'(tx_parity_type), 1);
      tick();
      tx_busy = 1'b1;
      repeat (11) tick();
      check("rr_ready_busy", 32'(req_ready), 0);
      tx_busy = 1'b0;
      tick();
    end

    // External transmitter use blocks acceptance
    req_valid = 4'b0001; tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ext_ready", 32'(req_ready), 0);
      check("ext_abusy", 32'(arb_busy), 0);
      tick();
    end
    tx_busy = 1'b0;
    #1;
    check("ext_accept", 32'(req_ready), 32'h1);
    tick();
    check("ext_grant", 32'(grant_id), 0);
    check("ext_txv", 32'(tx_data_valid), 1);
    tick();
    tx_busy = 1'b1;
    tick();

    // Reset while in WAIT_DONE
    reset = 1'b1; req_valid = '0; tx_busy = 1'b0;
    tick();
    reset = 1'b0;
    check("wdrst_abusy", 32'(arb_busy), 0);
    check("wdrst_ready", 32'(req_ready), 0);
    check("wdrst_txv", 32'(tx_data_valid), 0);
    check("wdrst_grant", 32'(grant_id), 0);
    check("wdrst_data", 32'(tx_parallel_data), 0);
    check("wdrst_pen", 32'(tx_parity_enable), 0);
    check("wdrst_ptype", 32'(tx_parity_type), 0);
    check("wdrst_tmo", 32'(timeout_err), 0);
    req_valid = 4'b1111;
    #1;
    check("wdrst_next0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("wdrst_grant0", 32'(grant_id), 0);
    tick();
    tx_busy = 1'b1; tick();
    tx_busy = 1'b0; tick();

    // Transmitter never responds after launch
    req_valid = 4'b0100; req_data = 32'h7E5A0000;
    #1;
    check("wd_ready2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1000;
    check("wd_grant2", 32'(grant_id), 2);
    check("wd_txv", 32'(tx_data_valid), 1);
    tick();
    check("wd_ready_wait", 32'(req_ready), 0);
`ifdef UART_TX_ARB_WATCHDOG_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      check("wd_tmo_early", 32'(timeout_err), 0);
      check("wd_abusy", 32'(arb_busy), 1);
    end
    tick();
    check("wd_tmo", 32'(timeout_err), 1);
    check("wd_idle", 32'(arb_busy), 0);
    check("wd_next_ready", 32'(req_ready), 32'h8);
    tick();
    check("wd_tmo_pulse", 32'(timeout_err), 0);
    check("wd_next_grant", 32'(grant_id), 3);
    check("wd_next_data", 32'(tx_parallel_data), 32'h7E);
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      check("nowd_tmo", 32'(timeout_err), 0);
      check("nowd_abusy", 32'(arb_busy), 1);
      check("nowd_ready", 32'(req_ready), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one transmit character.
REQ-002 Parameter NUM_REQ, default 4: number of requester ports (2..8).
REQ-003 Parameter TIMEOUT_CYCLES, default 16: watchdog limit in clocks.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester "character pending".
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  packed characters; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-009 parity_enable_cfg  input  1  parity enable applied to the accepted character.
REQ-010 parity_type_cfg  input  1  parity type applied to the accepted character (0 even, 1 odd).
REQ-011 tx_data_valid  output  1  launch strobe to the UART transmitter.
REQ-012 tx_parallel_data  output  DATA_WIDTH  character to the transmitter.
REQ-013 tx_parity_enable, tx_parity_type  output  1 each  latched parity configuration to the transmitter.
REQ-014 tx_busy  input  1  transmitter busy flag.
REQ-015 grant_id  output  clog2(NUM_REQ)  index of the requester currently owning the transmitter.
REQ-016 arb_busy  output  1  high in every state except IDLE.
REQ-017 timeout_err  output  1  one-cycle watchdog error pulse.

Function
REQ-018 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: when tx_busy=0 and any req_valid bit is 1, req_ready[w]=1 combinationally for that cycle only, where w is the round-robin winner.
REQ-020 On that edge, req_data slice w, parity_enable_cfg, parity_type_cfg and w are captured into tx_parallel_data, tx_parity_enable, tx_parity_type and grant_id; next state is LAUNCH.
REQ-021 Round-robin search starts at last_grant+1, wraps modulo NUM_REQ and ends at last_grant; last_grant updates on accept.
REQ-022 LAUNCH: tx_data_valid=1 for exactly one cycle; next state is WAIT_BUSY. Latency from accept to tx_data_valid is 1 clock.
REQ-023 WAIT_BUSY: remain until tx_busy=1, then go to WAIT_DONE.
REQ-024 WAIT_DONE: remain until tx_busy=0, then go to IDLE; a new accept is possible in that IDLE cycle.
REQ-025 IDLE with tx_busy=1 (external use of the transmitter): no accept, req_ready all 0.
REQ-026 Requesters hold req_valid and data stable until req_ready; dropping req_valid before grant is legal, and the request is then ignored.
REQ-027 Only one character is in flight; req_ready stays 0 in all non-IDLE states.
REQ-028 tx_parallel_data, tx_parity_* and grant_id hold their captured values until the next accept.

Reset
REQ-029 With reset=1 at a clock edge: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), and all outputs 0, including tx_data_valid, req_ready, grant_id and timeout_err.
REQ-030 Reset mid-operation (any state) aborts the frame on the next edge; the in-flight requester is not re-served automatically.

Configuration
REQ-031 Macro UART_TX_ARB_WATCHDOG_EN defined: a counter runs in WAIT_BUSY. If tx_busy stays 0 for TIMEOUT_CYCLES consecutive cycles, the FSM goes to IDLE, timeout_err pulses 1 for one cycle and the character is dropped. The counter clears on leaving WAIT_BUSY.
REQ-032 Macro undefined: WAIT_BUSY waits indefinitely, no counter is built, and timeout_err is tied to 0.

Verification
REQ-033 Single request: req_valid=4'b0010, data slice1=8'hE6, parity_enable=1, parity_type=0 -> req_ready=4'b0010 at cycle 0, tx_data_valid at cycle 1, tx_parallel_data=8'hE6, grant_id=1, arb_busy until tx_busy falls.
REQ-034 All four requesters valid continuously, with the transmitter model busy 11 clocks per frame -> grant order 0,1,2,3,0, with no requester served twice before the others.
REQ-035 External tx_busy=1 in IDLE with req_valid=4'b0001 -> no req_ready until tx_busy=0, then accept on the same cycle tx_busy is 0.
REQ-036 Reset asserted in WAIT_DONE -> next edge gives IDLE, all outputs 0, and the next accept goes to requester 0.
REQ-037 Watchdog build with tx_busy stuck 0 after launch -> timeout_err=1 exactly TIMEOUT_CYCLES=16 clocks after entering WAIT_BUSY, followed by IDLE and the next requester accepted.
REQ-038 Non-watchdog build with the same stimulus -> the FSM stays in WAIT_BUSY and timeout_err stays 0 for 100 clocks.
